// File: rtl/jk_excite_seq.sv
// -----------------------------------------------------------------------------
// jk_excite_seq
// Inverse of a JK flip-flop bank. Accepts a stream of desired next-state vectors,
// buffers them in a small FIFO, and emits the J/K excitation that drives a bank
// of WIDTH JK flip-flops from the modelled present state to each target in turn.
//
// Parameters
//   WIDTH     number of JK FFs driven (bits per vector)
//   DEPTH     target FIFO entries (power of 2, >= 2)
//   DC_POLICY don't-care fill: 0 -> 0 (hold/set/reset), 1 -> 1 (toggle-preferred)
//   RESET_Q   q_model value after reset, replicated over all bits
//
// Ports
//   i_clk          rising-edge clock
//   i_rst          synchronous reset, active-high
//   i_in_valid     target vector valid
//   o_in_ready     FIFO can accept (not full)
//   i_in_target    desired next Q of each FF
//   o_out_valid    o_j_out/o_k_out hold a pending excitation beat
//   i_out_ready    consumer takes the beat this edge
//   o_j_out        J excitation
//   o_k_out        K excitation
//   o_q_model      modelled FF state after all beats loaded so far
//   o_fifo_count   current FIFO occupancy
//
// Optional feature (macro JK_CHECK_EN)
//   i_q_fb         observed FF bank state
//   o_mismatch     sticky flag: observed state differed from an accepted target
//   o_err_cnt      number of such differences, saturating at 255
// -----------------------------------------------------------------------------
module jk_excite_seq #(
    parameter int WIDTH     = 1,
    parameter int DEPTH     = 4,
    parameter int DC_POLICY = 0,
    parameter bit RESET_Q   = 1'b0
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [WIDTH-1:0]         i_in_target,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [WIDTH-1:0]         o_j_out,
    output logic [WIDTH-1:0]         o_k_out,
    output logic [WIDTH-1:0]         o_q_model,
    output logic [$clog2(DEPTH):0]   o_fifo_count
`ifdef JK_CHECK_EN
    ,
    input  logic [WIDTH-1:0]         i_q_fb,
    output logic                     o_mismatch,
    output logic [7:0]               o_err_cnt
`endif
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_j;
    logic [WIDTH-1:0] r_k;
    logic [WIDTH-1:0] r_q_model;

    logic             w_full;
    logic             w_push;
    logic             w_load;
    logic [WIDTH-1:0] w_head;
    logic [WIDTH-1:0] w_dc;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;

    assign w_full = (r_count == FULL_CNT);
    assign w_push = i_in_valid && !w_full;
    // The output register refills whenever it is empty or being drained.
    assign w_load = (!r_out_valid || i_out_ready) && (r_count != '0);
    assign w_head = r_mem[r_rd_ptr];
    assign w_dc   = {WIDTH{DC_POLICY != 0}};

    // q=0: J follows the target, K is don't-care.
    // q=1: J is don't-care, K is the inverted target.
    assign w_j = (r_q_model & w_dc) | (~r_q_model & w_head);
    assign w_k = (r_q_model & ~w_head) | (~r_q_model & w_dc);

    always_ff @(posedge i_clk) begin
        if (w_push && !i_rst) begin
            r_mem[r_wr_ptr] <= i_in_target;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            r_j         <= '0;
            r_k         <= '0;
            r_q_model   <= {WIDTH{RESET_Q}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_load) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_j       <= w_j;
                r_k       <= w_k;
                r_q_model <= w_head;
            end
            if (w_push && !w_load) begin
                r_count <= r_count + (AW + 1)'(1);
            end else if (!w_push && w_load) begin
                r_count <= r_count - (AW + 1)'(1);
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef JK_CHECK_EN
    logic [WIDTH-1:0] r_out_tgt;
    logic [WIDTH-1:0] r_chk_exp;
    logic             r_chk_pend;
    logic             r_mismatch;
    logic [7:0]       r_err_cnt;

    // A beat accepted at one edge is checked against the feedback seen at the
    // next edge, once the FF bank has had a clock to act on it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_tgt  <= '0;
            r_chk_exp  <= '0;
            r_chk_pend <= 1'b0;
            r_mismatch <= 1'b0;
            r_err_cnt  <= '0;
        end else begin
            if (w_load) begin
                r_out_tgt <= w_head;
            end
            r_chk_pend <= r_out_valid && i_out_ready;
            r_chk_exp  <= r_out_tgt;
            if (r_chk_pend && (i_q_fb != r_chk_exp)) begin
                r_mismatch <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end
            end
        end
    end

    assign o_mismatch = r_mismatch;
    assign o_err_cnt  = r_err_cnt;
`endif

    assign o_in_ready   = !w_full;
    assign o_out_valid  = r_out_valid;
    assign o_j_out      = r_j;
    assign o_k_out      = r_k;
    assign o_q_model    = r_q_model;
    assign o_fifo_count = r_count;

endmodule
